// File: rtl/fp_mul_arbiter32_pkg.sv
// Shared types and constants for the arbitrated FP32 multiplier slice.
// The expanded product word is {sign, exp[9:0], sig[47:0]}; normalization happens downstream.
package fp_mul_arbiter32_pkg;

  localparam int FP_MUL_LAT = 14;
  localparam int FP_EXP_W   = 10;
  localparam int FP_SIG_W   = 48;
  localparam int FP_EX      = FP_EXP_W + FP_SIG_W;  // index of the sign bit

  typedef struct packed {
    logic       v;
    logic [2:0] idx;
  } fp_mul_tag_t;

  typedef struct packed {
    logic inf;
    logic overflow;
    logic underflow;
    logic sign_exe;
  } fp_mul_flags_t;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_SIG_W-1:0] sig;
  } fp_ex_t;

endpackage

// File: rtl/fp_mul_arbiter32_fpmul.sv
// FP32 multiplier producing an unnormalized expanded product after DELAY+1 enabled clocks.
// Denormal inputs are flushed to zero; NaN results are a quiet NaN with the sig MSB set.
module fpMultiply32
  import fp_mul_arbiter32_pkg::*;
#(
  parameter int DELAY = FP_MUL_LAT - 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic [31:0]   a,
  input  logic [31:0]   b,
  output logic [FP_EX:0] o,
  output logic [3:0]    flags
);

  localparam int NST = DELAY + 1;

  logic [7:0]          ea, eb;
  logic [22:0]         fa, fb;
  logic                a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic                is_nan, is_inf, is_zero;
  logic [FP_EXP_W-1:0] exp_sum;
  logic [FP_SIG_W-1:0] ma, mb;
  fp_ex_t              res_next;
  fp_mul_flags_t       flg_next;
  logic [FP_EX+4:0]    pipe_reg [NST];

  always_comb begin
    ea      = a[30:23];
    eb      = b[30:23];
    fa      = a[22:0];
    fb      = b[22:0];
    a_zero  = (ea == 8'd0);
    b_zero  = (eb == 8'd0);
    a_inf   = (ea == 8'hFF) && (fa == 23'd0);
    b_inf   = (eb == 8'hFF) && (fb == 23'd0);
    a_nan   = (ea == 8'hFF) && (fa != 23'd0);
    b_nan   = (eb == 8'hFF) && (fb != 23'd0);
    is_nan  = a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf);
    is_inf  = (a_inf || b_inf) && !is_nan;
    is_zero = (a_zero || b_zero) && !is_nan && !is_inf;
    // Two's-complement biased exponent; bit 9 set means it went below zero.
    exp_sum = {2'b00, ea} + {2'b00, eb} - 10'd127;
    ma      = {24'd0, 1'b1, fa};
    mb      = {24'd0, 1'b1, fb};

    res_next.sign      = a[31] ^ b[31];
    res_next.exp       = exp_sum;
    res_next.sig       = ma * mb;
    flg_next.inf       = 1'b0;
    flg_next.overflow  = !exp_sum[9] && (exp_sum >= 10'd255);
    flg_next.underflow = exp_sum[9] || (exp_sum == 10'd0);
    flg_next.sign_exe  = 1'b0;

    if (is_nan) begin
      res_next.exp = '1;
      res_next.sig = {1'b1, {(FP_SIG_W-1){1'b0}}};
      flg_next     = 4'b0001;
    end else if (is_inf) begin
      res_next.exp = '1;
      res_next.sig = '0;
      flg_next     = 4'b1000;
    end else if (is_zero) begin
      res_next.exp = '0;
      res_next.sig = '0;
      flg_next     = 4'b0000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NST; k++) pipe_reg[k] <= '0;
    end else if (ce) begin
      pipe_reg[0] <= {res_next, flg_next};
      for (int k = 1; k < NST; k++) pipe_reg[k] <= pipe_reg[k-1];
    end
  end

  assign o     = pipe_reg[NST-1][FP_EX+4:4];
  assign flags = pipe_reg[NST-1][3:0];

endmodule

// File: rtl/fp_mul_arbiter32_rr_arbiter.sv
// Combinational round-robin arbiter: the first request at or after ptr wins.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  // Scan from the farthest slot back to ptr so the nearest request is written last.
  always_comb begin
    int j;
    j         = 0;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        grant     = '0;
        grant[j]  = 1'b1;
        grant_idx = IW'(j);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_mul_arbiter32.sv
// Shares one fpMultiply32 among NREQ requesters with round-robin issue, per-requester
// credit limits and a tag pipe that routes each product back to its requester.
module fp_mul_arbiter32
  import fp_mul_arbiter32_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = FP_MUL_LAT,
  parameter int MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  output logic [NREQ-1:0]   resp_valid,
  output logic [FP_EX:0]    resp_o,
  output logic [3:0]        resp_flags,
  output logic              busy
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = 4;
  localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUT);

  logic [IW-1:0] ptr_reg, ptr_next;
  logic [NREQ-1:0] eligible, grant;
  logic [IW-1:0] grant_idx;
  logic          grant_any;
  logic [31:0]   mul_a, mul_b;
  fp_mul_tag_t   tag_reg [MUL_LAT];
  fp_mul_tag_t   tag_in, tail;

  assign tail = tag_reg[MUL_LAT-1];

  always_comb begin
    resp_valid = '0;
    for (int i = 0; i < NREQ; i++)
      if (tail.v && !stall && (tail.idx == 3'(i))) resp_valid[i] = 1'b1;
  end

  // A credit returning this cycle may be reused at once, so a full requester keeps one issue per response.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    logic [CW-1:0] cnt_reg;
    assign eligible[gi] = req_valid[gi] && !stall && ((cnt_reg < MAX_OUT_C) || resp_valid[gi]);
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                            cnt_reg <= '0;
      else if (grant[gi] && !resp_valid[gi]) cnt_reg <= cnt_reg + 1'b1;
      else if (!grant[gi] && resp_valid[gi]) cnt_reg <= cnt_reg - 1'b1;
    end
  end

  rr_arbiter #(.N(NREQ)) u_arb (
    .req       (eligible),
    .ptr       (ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  assign req_ready = grant;

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        mul_a = req_a[i*32 +: 32];
        mul_b = req_b[i*32 +: 32];
      end
    end
    ptr_next = ptr_reg;
    if (grant_any) ptr_next = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    tag_in               = '0;
    tag_in.v             = grant_any;
    tag_in.idx[IW-1:0]   = grant_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_reg <= '0;
    else        ptr_reg <= ptr_next;
  end

  // Tag pipe advances exactly when the multiplier does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MUL_LAT; k++) tag_reg[k] <= '0;
    end else if (!stall) begin
      tag_reg[0] <= tag_in;
      for (int k = 1; k < MUL_LAT; k++) tag_reg[k] <= tag_reg[k-1];
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < MUL_LAT; k++) busy = busy | tag_reg[k].v;
  end

  fpMultiply32 #(.DELAY(MUL_LAT - 1)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (!stall),
    .a     (mul_a),
    .b     (mul_b),
    .o     (resp_o),
    .flags (resp_flags)
  );

endmodule

// File: tb/tb_fp_mul_arbiter32.sv
// Directed bench for fp_mul_arbiter32: per-cycle stimulus tables with hand-computed
// grants, response strobes, products and busy.
module tb_fp_mul_arbiter32;
  import fp_mul_arbiter32_pkg::*;

  localparam int NREQ = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                stall = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready, resp_valid;
  logic [NREQ*32-1:0]  req_a = '0, req_b = '0;
  logic [FP_EX:0]      resp_o;
  logic [3:0]          resp_flags;
  logic                busy;

  int n_vec = 0;
  int n_bad = 0;

  logic [3:0]     vpat    [64];
  logic           stpat   [64];
  logic           rstpat  [64];
  logic [3:0]     exp_rdy [64];
  logic [3:0]     exp_rsp [64];
  logic [FP_EX:0] exp_res [64];
  logic [3:0]     exp_flg [64];
  int             exp_bsy [64];

  // Hand-computed expanded products {sign, exp10, sig48}
  localparam logic [FP_EX:0] R_1X2   = {1'b0, 10'h080, 48'h4000_0000_0000};
  localparam logic [FP_EX:0] R_15X2  = {1'b0, 10'h080, 48'h6000_0000_0000};
  localparam logic [FP_EX:0] R_15X15 = {1'b0, 10'h07F, 48'h9000_0000_0000};
  localparam logic [FP_EX:0] R_M1X3  = {1'b1, 10'h080, 48'h6000_0000_0000};
  localparam logic [FP_EX:0] R_4XM5  = {1'b1, 10'h083, 48'h5000_0000_0000};
  localparam logic [FP_EX:0] R_NAN   = {1'b0, 10'h3FF, 48'h8000_0000_0000};

  always #5 clk = ~clk;

  fp_mul_arbiter32 #(.NREQ(NREQ), .MUL_LAT(14), .MAX_OUT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_o     (resp_o),
    .resp_flags (resp_flags),
    .busy       (busy)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
  endtask

  task automatic clear_tables();
    for (int c = 0; c < 64; c++) begin
      vpat[c] = '0; stpat[c] = 1'b0; rstpat[c] = 1'b0;
      exp_rdy[c] = '0; exp_rsp[c] = '0; exp_res[c] = '0; exp_flg[c] = '0;
      exp_bsy[c] = -1;
    end
  endtask

  task automatic do_reset(input string name);
    req_valid = '0;
    stall     = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val({name, " rst ready"}, 64'(req_ready), 64'h0);
    check_val({name, " rst resp_valid"}, 64'(resp_valid), 64'h0);
    check_val({name, " rst resp_o"}, 64'(resp_o), 64'h0);
    check_val({name, " rst flags"}, 64'(resp_flags), 64'h0);
    check_val({name, " rst busy"}, 64'(busy), 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run(input string name, input int n);
    for (int c = 0; c < n; c++) begin
      req_valid = vpat[c];
      stall     = stpat[c];
      rst_n     = !rstpat[c];
      @(negedge clk);
      check_val($sformatf("%s c%0d ready", name, c), 64'(req_ready), 64'(exp_rdy[c]));
      check_val($sformatf("%s c%0d resp_valid", name, c), 64'(resp_valid), 64'(exp_rsp[c]));
      if (exp_rsp[c] != 4'd0) begin
        check_val($sformatf("%s c%0d resp_o", name, c), 64'(resp_o), 64'(exp_res[c]));
        check_val($sformatf("%s c%0d flags", name, c), 64'(resp_flags), 64'(exp_flg[c]));
      end
      if (exp_bsy[c] >= 0)
        check_val($sformatf("%s c%0d busy", name, c), 64'(busy), 64'(exp_bsy[c]));
      if (resp_valid != '0)
        $display("%s c%0d resp_valid=%b resp_o=%h flags=%b", name, c, resp_valid, resp_o, resp_flags);
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    stall     = 1'b0;
    rst_n     = 1'b1;
  endtask

  initial begin
    // Single op: 1.5 * 2.0 from req0
    clear_tables();
    set_ops(0, 32'h3FC00000, 32'h40000000);
    vpat[0] = 4'b0001; exp_rdy[0] = 4'b0001;
    exp_rsp[14] = 4'b0001; exp_res[14] = R_15X2; exp_flg[14] = 4'b0000;
    exp_bsy[0] = 0;
    for (int c = 1; c <= 14; c++) exp_bsy[c] = 1;
    for (int c = 15; c < 20; c++) exp_bsy[c] = 0;
    do_reset("single");
    run("single", 20);

    // Fairness: all four held for 8 cycles
    clear_tables();
    set_ops(0, 32'h3F800000, 32'h40000000);
    set_ops(1, 32'h3FC00000, 32'h3FC00000);
    set_ops(2, 32'hBF800000, 32'h40400000);
    set_ops(3, 32'h40800000, 32'hC0A00000);
    for (int c = 0; c < 8; c++) begin
      vpat[c]         = 4'b1111;
      exp_rdy[c]      = 4'b0001 << (c % 4);
      exp_rsp[c + 14] = 4'b0001 << (c % 4);
      case (c % 4)
        0:       exp_res[c + 14] = R_1X2;
        1:       exp_res[c + 14] = R_15X15;
        2:       exp_res[c + 14] = R_M1X3;
        default: exp_res[c + 14] = R_4XM5;
      endcase
    end
    do_reset("fair");
    run("fair", 24);

    // Credit limit: req2 alone for 20 cycles with MAX_OUT=4
    clear_tables();
    for (int c = 0; c < 20; c++) vpat[c] = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      exp_rdy[c]      = 4'b0100;
      exp_rdy[c + 14] = 4'b0100;
      exp_rsp[c + 14] = 4'b0100;
      exp_res[c + 14] = R_M1X3;
    end
    do_reset("credit");
    run("credit", 22);

    // Stall in cycles 5-7 delays the req0 response to cycle 17; req1 waits out the stall
    clear_tables();
    set_ops(0, 32'h3FC00000, 32'h40000000);
    set_ops(1, 32'h3FC00000, 32'h3FC00000);
    vpat[0] = 4'b0001; exp_rdy[0] = 4'b0001;
    for (int c = 5; c <= 8; c++) vpat[c] = 4'b0010;
    for (int c = 5; c <= 7; c++) stpat[c] = 1'b1;
    exp_rdy[8] = 4'b0010;
    exp_rsp[17] = 4'b0001; exp_res[17] = R_15X2;
    exp_rsp[22] = 4'b0010; exp_res[22] = R_15X15;
    exp_bsy[6] = 1; exp_bsy[17] = 1; exp_bsy[18] = 1;
    do_reset("stall");
    run("stall", 26);

    // Special values: inf * 0 from req1 gives a quiet NaN
    clear_tables();
    set_ops(1, 32'h7F800000, 32'h00000000);
    vpat[0] = 4'b0010; exp_rdy[0] = 4'b0010;
    exp_rsp[14] = 4'b0010; exp_res[14] = R_NAN; exp_flg[14] = 4'b0001;
    do_reset("special");
    run("special", 18);

    // Reset mid-flight: nothing may emerge; counters restart at zero
    clear_tables();
    set_ops(0, 32'h3F800000, 32'h40000000);
    for (int c = 0; c < 3; c++) begin
      vpat[c]    = 4'b0111;
      exp_rdy[c] = 4'b0001 << c;
    end
    rstpat[5] = 1'b1;
    exp_bsy[0] = 0;
    for (int c = 1; c <= 4; c++) exp_bsy[c] = 1;
    for (int c = 5; c <= 31; c++) exp_bsy[c] = 0;
    for (int c = 31; c <= 36; c++) vpat[c] = 4'b0001;
    for (int c = 31; c <= 34; c++) exp_rdy[c] = 4'b0001;
    for (int c = 32; c < 40; c++) exp_bsy[c] = 1;
    do_reset("midrst");
    run("midrst", 40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
